// File: rtl/i2s_pkg.sv
// Shared types and helpers for the serial-audio receiver.
package i2s_pkg;
    localparam int SLOT_BITS = 32;

    typedef enum logic [1:0] {
        STD_PHILIPS = 2'b00,
        STD_LJ      = 2'b01,
        STD_RSVD2   = 2'b10,
        STD_RSVD3   = 2'b11
    } standard_t;

    typedef enum logic [1:0] {
        WSZ_32 = 2'b00,
        WSZ_24 = 2'b01,
        WSZ_16 = 2'b10,
        WSZ_8  = 2'b11
    } word_size_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SHIFT,
        ST_PUSH
    } rx_state_t;

    // Captured bits per slot, never wider than the stored word.
    function automatic int word_bits(word_size_t wsz, int data_w);
        int w;
        case (wsz)
            WSZ_32:  w = 32;
            WSZ_24:  w = 24;
            WSZ_16:  w = 16;
            default: w = 8;
        endcase
        return (w > data_w) ? data_w : w;
    endfunction
endpackage

// File: rtl/i2s_rx_tdm_fifo_if.sv
// Frame pop port: valid/ready handshake plus head frame and fill level.
interface i2s_rx_tdm_fifo_if #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8
);
    logic                         rd_valid;
    logic                         rd_ready;
    logic [CHANNELS*DATA_W-1:0]   rd_data;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport master (output rd_valid, rd_data, level, input rd_ready);
    modport slave  (input rd_valid, rd_data, level, output rd_ready);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through single-clock FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/i2s_rx_tdm_fifo.sv
// Single-clock I2S / left-justified TDM receiver assembling one frame per FIFO entry.
// state | meaning: HUNT wait for ws fall | SHIFT capturing slots | PUSH write completed frame
module i2s_rx_tdm_fifo
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   bit_en,
    input  logic                   ws,
    input  logic                   din,
    input  logic [1:0]             standard,
    input  logic [1:0]             word_size,
    input  logic                   ovf_clr,
    output logic                   overflow,
    output logic                   frame_err,
    i2s_rx_tdm_fifo_if.master      rd
);
    localparam int FW = CHANNELS * DATA_W;
    localparam int BW = $clog2(SLOT_BITS);
    localparam int SW = $clog2(CHANNELS);

    rx_state_t         state;
    logic              ws_prev;
    logic              armed;
    logic [BW-1:0]     bit_cnt;
    logic [SW-1:0]     slot_cnt;
    logic [DATA_W-1:0] word;
    logic [FW-1:0]     frame;
    logic [FW-1:0]     out_frame;

    logic              fall;
    logic              lj;
    logic              shifting;
    logic              last_bit;
    logic [5:0]        wbits;
    logic [DATA_W-1:0] word_nx;
    logic [DATA_W-1:0] word_al;
    logic [FW-1:0]     frame_nx;
    logic              push_req;
    logic              full;
    logic              empty;
    logic              pop;
    logic              drop;

    always_comb begin
        fall     = bit_en && ws_prev && !ws;
        lj       = (standard == STD_LJ);
        shifting = (state == ST_SHIFT) || ((state == ST_PUSH) && armed);
        last_bit = (bit_cnt == BW'(SLOT_BITS-1)) && (slot_cnt == SW'(CHANNELS-1));
        wbits    = 6'(word_bits(word_size_t'(word_size), DATA_W));
        word_nx  = ({1'b0, bit_cnt} < wbits) ? {word[DATA_W-2:0], din} : word;
        word_al  = word_nx << (6'(DATA_W) - wbits);
        frame_nx = frame;
        frame_nx[int'(slot_cnt)*DATA_W +: DATA_W] = word_al;
    end

    assign push_req = (state == ST_PUSH);
    assign pop      = rd.rd_ready && !empty;
    assign drop     = push_req && full && !pop;
    assign rd.rd_valid = !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            ws_prev   <= 1'b1;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            word      <= '0;
            frame     <= '0;
            out_frame <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            armed     <= 1'b0;
            if (bit_en) ws_prev <= ws;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (!en) begin
                state <= ST_HUNT;
            end else begin
                case (state)
                    ST_HUNT: if (fall) state <= ST_SHIFT;
                    ST_PUSH: state <= (armed || fall) ? ST_SHIFT : ST_HUNT;
                    default: ;
                endcase

                // A fall on the final bit completes the frame and also opens the next one.
                if (fall && !(shifting && last_bit)) begin
                    if (shifting) frame_err <= 1'b1;
                    state    <= ST_SHIFT;
                    slot_cnt <= '0;
                    bit_cnt  <= lj ? BW'(1) : '0;
                    word     <= lj ? {{(DATA_W-1){1'b0}}, din} : '0;
                end else if (bit_en && shifting) begin
                    word    <= word_nx;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(SLOT_BITS-1)) begin
                        frame    <= frame_nx;
                        word     <= '0;
                        slot_cnt <= slot_cnt + SW'(1);
                        if (last_bit) begin
                            out_frame <= frame_nx;
                            state     <= ST_PUSH;
                            slot_cnt  <= '0;
                            if (fall) begin
                                armed   <= 1'b1;
                                bit_cnt <= lj ? BW'(1) : '0;
                                word    <= lj ? {{(DATA_W-1){1'b0}}, din} : '0;
                            end
                        end
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (out_frame),
        .pop       (pop),
        .pop_data  (rd.rd_data),
        .full      (full),
        .empty     (empty),
        .level     (rd.level)
    );
endmodule

// File: tb/tb_i2s_rx_tdm_fifo.sv
// Directed bench: stereo Philips and 4-channel left-justified receivers fed from one serial stream.
module tb_i2s_rx_tdm_fifo;
    logic       clk = 1'b0;
    logic       rst_n, en_st, en_tdm, bit_en, ws, din, ovf_clr;
    logic [1:0] standard, word_size;
    logic       ovf_st, ovf_tdm, ferr_st, ferr_tdm;

    int checks = 0;
    int errors = 0;
    logic [1:0]  q[$];
    logic [31:0] fw[8];

    always #5 clk = ~clk;

    i2s_rx_tdm_fifo_if #(.DATA_W(32), .CHANNELS(2), .DEPTH(8)) st_if ();
    i2s_rx_tdm_fifo_if #(.DATA_W(32), .CHANNELS(4), .DEPTH(8)) tdm_if ();

    i2s_rx_tdm_fifo #(.DATA_W(32), .DEPTH(8), .CHANNELS(2)) u_st (
        .clk(clk), .rst_n(rst_n), .en(en_st), .bit_en(bit_en), .ws(ws), .din(din),
        .standard(standard), .word_size(word_size), .ovf_clr(ovf_clr),
        .overflow(ovf_st), .frame_err(ferr_st), .rd(st_if.master)
    );

    i2s_rx_tdm_fifo #(.DATA_W(32), .DEPTH(8), .CHANNELS(4)) u_tdm (
        .clk(clk), .rst_n(rst_n), .en(en_tdm), .bit_en(bit_en), .ws(ws), .din(din),
        .standard(standard), .word_size(word_size), .ovf_clr(ovf_clr),
        .overflow(ovf_tdm), .frame_err(ferr_tdm), .rd(tdm_if.master)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic d);
        q.push_back({w, d});
    endtask

    // Philips bits k0..k1 of a frame (k=1 is the MSB of slot 0); ws rises at bit 32.
    task automatic add_ph_bits(input logic [31:0] w[8], input int nch, input int k0,
                               input int k1, input logic last_ws);
        logic wsv;
        for (int k = k0; k <= k1; k++) begin
            if (k < 32)            wsv = 1'b0;
            else if (k == 32*nch)  wsv = last_ws;
            else                   wsv = 1'b1;
            add(wsv, w[(k-1)/32][31-((k-1)%32)]);
        end
    endtask

    task automatic add_philips(input logic [31:0] w[8], input int nch);
        add(1'b1, 1'b0);
        add(1'b0, 1'b0);
        add_ph_bits(w, nch, 1, 32*nch, 1'b1);
    endtask

    task automatic add_lj(input logic [31:0] w[8], input int nch);
        add(1'b1, 1'b0);
        for (int k = 0; k < 32*nch; k++)
            add((k < 32) ? 1'b0 : 1'b1, w[k/32][31-(k%32)]);
    endtask

    // Returns #1 after the clock edge that sampled the last queued bit.
    task automatic play(input int gap);
        logic [1:0] e;
        bit first;
        first = 1'b1;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (!first)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bit_en = 1'b0;
                end
            first = 1'b0;
            @(negedge clk);
            ws = e[1]; din = e[0]; bit_en = 1'b1;
            @(posedge clk);
        end
        #1;
        bit_en = 1'b0;
    endtask

    task automatic pop_st();
        @(negedge clk);
        st_if.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        st_if.rd_ready = 1'b0;
    endtask

    task automatic send_st(input logic [31:0] a, input logic [31:0] b);
        fw[0] = a; fw[1] = b;
        add_philips(fw, 2);
        play(0);
        step(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en_st = 1'b0; en_tdm = 1'b0; bit_en = 1'b0; ws = 1'b1; din = 1'b0;
        standard = 2'b00; word_size = 2'b00; ovf_clr = 1'b0;
        st_if.rd_ready = 1'b0; tdm_if.rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) fw[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", st_if.rd_valid, 1'b0);
        chk("rst_level", st_if.level, 4'd0);
        chk("rst_data", st_if.rd_data, 64'h0);
        chk("rst_ovf", ovf_st, 1'b0);
        chk("rst_ferr", ferr_st, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stereo Philips 32b with latency check
        en_st = 1'b1;
        fw[0] = 32'hA5A5_0001; fw[1] = 32'h5A5A_0002;
        add_philips(fw, 2);
        play(1);
        chk("ph_valid_at_T", st_if.rd_valid, 1'b0);
        step();
        chk("ph_valid_at_T1", st_if.rd_valid, 1'b1);
        chk("ph_data", st_if.rd_data, 64'h5A5A0002_A5A50001);
        chk("ph_level", st_if.level, 4'd1);
        pop_st();
        chk("ph_pop_level", st_if.level, 4'd0);
        chk("ph_pop_valid", st_if.rd_valid, 1'b0);

        // Four-channel left-justified 16b
        en_st = 1'b0; en_tdm = 1'b1; standard = 2'b01; word_size = 2'b10;
        fw[0] = 32'h1234_5678; fw[1] = 32'h5678_9ABC; fw[2] = 32'h9ABC_DEF0; fw[3] = 32'hDEF0_1234;
        add_lj(fw, 4);
        play(0);
        step(); step();
        chk("lj_valid", tdm_if.rd_valid, 1'b1);
        chk("lj_data", tdm_if.rd_data, 128'hDEF00000_9ABC0000_56780000_12340000);
        chk("lj_st_idle", st_if.level, 4'd0);
        @(negedge clk); tdm_if.rd_ready = 1'b1;
        step();
        tdm_if.rd_ready = 1'b0;
        chk("lj_pop_level", tdm_if.level, 4'd0);
        en_tdm = 1'b0; standard = 2'b00; word_size = 2'b00; fw[2] = '0; fw[3] = '0;

        // Nine frames into eight entries
        en_st = 1'b1;
        for (int i = 0; i < 9; i++) send_st(32'h1000_0000 + i, 32'h2000_0000 + i);
        chk("ovf_level", st_if.level, 4'd8);
        chk("ovf_flag", ovf_st, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), st_if.rd_data, {32'h2000_0000 + i, 32'h1000_0000 + i});
            pop_st();
        end
        chk("ovf_drained", st_if.rd_valid, 1'b0);
        @(negedge clk); ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf_st, 1'b0);

        // Full FIFO with a pop in the PUSH cycle
        for (int i = 0; i < 8; i++) send_st(32'h3000_0000 + i, 32'h4000_0000 + i);
        fw[0] = 32'h3000_0008; fw[1] = 32'h4000_0008;
        add_philips(fw, 2);
        play(0);
        @(negedge clk); st_if.rd_ready = 1'b1;
        step();
        st_if.rd_ready = 1'b0;
        step();
        chk("fullpop_level", st_if.level, 4'd8);
        chk("fullpop_ovf", ovf_st, 1'b0);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("fullpop_pop%0d", i), st_if.rd_data, {32'h4000_0000 + i, 32'h3000_0000 + i});
            pop_st();
        end

        // Early ws fall after 40 bits
        fw[0] = 32'hFFFF_0000; fw[1] = 32'h00FF_00FF;
        add(1'b1, 1'b0); add(1'b0, 1'b0);
        add_ph_bits(fw, 2, 1, 40, 1'b1);
        add(1'b0, 1'b1);
        play(1);
        chk("ferr_pulse", ferr_st, 1'b1);
        step();
        chk("ferr_clear", ferr_st, 1'b0);
        chk("ferr_nopush", st_if.level, 4'd0);
        fw[0] = 32'hCAFE_0005; fw[1] = 32'hBEEF_0006;
        add_ph_bits(fw, 2, 1, 64, 1'b1);
        play(1);
        step(); step();
        chk("ferr_next_level", st_if.level, 4'd1);
        chk("ferr_next_data", st_if.rd_data, 64'hBEEF0006_CAFE0005);
        pop_st();

        // Enable dropped mid-frame
        fw[0] = 32'h1111_2222; fw[1] = 32'h3333_4444;
        add(1'b1, 1'b0); add(1'b0, 1'b0);
        add_ph_bits(fw, 2, 1, 30, 1'b1);
        play(1);
        @(negedge clk); en_st = 1'b0;
        step(); step();
        en_st = 1'b1;
        add_ph_bits(fw, 2, 31, 64, 1'b1);
        play(1);
        step(); step(); step();
        chk("en_nopush", st_if.level, 4'd0);
        send_st(32'h7777_0001, 32'h8888_0002);
        chk("en_next_data", st_if.rd_data, 64'h88880002_77770001);
        pop_st();

        // Back-to-back Philips frames, edge shared with the final bit
        fw[0] = 32'hAAAA_0001; fw[1] = 32'hBBBB_0002;
        add(1'b1, 1'b0); add(1'b0, 1'b0);
        add_ph_bits(fw, 2, 1, 64, 1'b0);
        fw[0] = 32'hCCCC_0003; fw[1] = 32'hDDDD_0004;
        add_ph_bits(fw, 2, 1, 64, 1'b1);
        play(0);
        step(); step();
        chk("b2b_level", st_if.level, 4'd2);
        chk("b2b_first", st_if.rd_data, 64'hBBBB0002_AAAA0001);
        pop_st();
        chk("b2b_second", st_if.rd_data, 64'hDDDD0004_CCCC0003);
        pop_st();

        // Reset mid-frame with three stored frames
        for (int i = 0; i < 3; i++) send_st(32'h5000_0000 + i, 32'h6000_0000 + i);
        chk("mrst_pre_level", st_if.level, 4'd3);
        add(1'b1, 1'b0); add(1'b0, 1'b0);
        add_ph_bits(fw, 2, 1, 20, 1'b1);
        play(1);
        @(negedge clk); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_level", st_if.level, 4'd0);
        chk("mrst_valid", st_if.rd_valid, 1'b0);
        chk("mrst_data", st_if.rd_data, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
